// File: rtl/kcuart_tx_buf.sv
// kcuart_tx_buf: transmit byte FIFO feeding the compact UART transmitter.
// Holds send_character_o high across queued bytes so characters go out back-to-back.
// Optional overflow flag: define KCUART_TX_BUF_OVF_EN to add ovf_clr_i / ovf_o.
module kcuart_tx_buf #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_data_i,
  input  logic              flush_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic [7:0]        tx_data_o,
  output logic              send_character_o,
  input  logic              tx_complete_i,
`ifdef KCUART_TX_BUF_OVF_EN
  output logic              tx_busy_o,
  input  logic              ovf_clr_i,
  output logic              ovf_o
`else
  output logic              tx_busy_o
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  state_e          state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            send_q, send_d;
  logic            wr_acc;
  logic            pop;
  logic [7:0]      head;

  assign head = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Write acceptance and pop decision; pop uses registered empty, flush cancels it
  always_comb begin
    wr_acc = wr_en_i & ~full_q & ~flush_i;
    pop    = 1'b0;
    if (~flush_i && ~empty_q) begin
      if (state_q == ST_IDLE)
        pop = 1'b1;
      else if (tx_complete_i)
        pop = 1'b1;
    end
  end

  // Next pointers and registered status flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
  end

  // Transmit FSM next state: load a byte on pop, drop send only when drained
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    send_d    = send_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_data_d = head;
          send_d    = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_complete_i) begin
          if (pop) begin
            tx_data_d = head;
          end else if (empty_q) begin
            send_d  = 1'b0;
            state_d = ST_IDLE;
          end
          // a flush-cancelled pop keeps the current byte in SEND until the next completion
        end
      end
      default: begin
        state_d = ST_IDLE;
        send_d  = 1'b0;
      end
    endcase
  end

  // FIFO storage; no reset needed, validity tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
  end

  // FIFO pointers and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Transmit FSM with registered data/send outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      send_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      send_q    <= send_d;
    end
  end

`ifdef KCUART_TX_BUF_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (wr_en_i & full_q & ~flush_i) ovf_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif

  assign full_o           = full_q;
  assign empty_o          = empty_q;
  assign level_o          = wr_ptr_q - rd_ptr_q;
  assign tx_data_o        = tx_data_q;
  assign send_character_o = send_q;
  assign tx_busy_o        = send_q;

endmodule

// File: tb/tb_kcuart_tx_buf.sv
// Testbench for kcuart_tx_buf: scoreboard of written bytes checked as the FSM pops them.
module tb_kcuart_tx_buf;

  localparam int unsigned ADDR_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en_i;
  logic [7:0]      wr_data_i;
  logic            flush_i;
  logic            full_o;
  logic            empty_o;
  logic [ADDR_W:0] level_o;
  logic [7:0]      tx_data_o;
  logic            send_character_o;
  logic            tx_complete_i;
  logic            tx_busy_o;
`ifdef KCUART_TX_BUF_OVF_EN
  logic            ovf_clr_i;
  logic            ovf_o;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [7:0]  sb[$];

  kcuart_tx_buf #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_en_i          (wr_en_i),
    .wr_data_i        (wr_data_i),
    .flush_i          (flush_i),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .level_o          (level_o),
    .tx_data_o        (tx_data_o),
    .send_character_o (send_character_o),
    .tx_complete_i    (tx_complete_i),
`ifdef KCUART_TX_BUF_OVF_EN
    .tx_busy_o        (tx_busy_o),
    .ovf_clr_i        (ovf_clr_i),
    .ovf_o            (ovf_o)
`else
    .tx_busy_o        (tx_busy_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_en_i   = 1'b1;
    wr_data_i = b;
    step();
    wr_en_i   = 1'b0;
    if (accept) sb.push_back(b);
  endtask

  task automatic cmpl();
    tx_complete_i = 1'b1;
    step();
    tx_complete_i = 1'b0;
  endtask

  // Compare the byte the FSM just loaded against the oldest scoreboard entry
  task automatic chk_pop(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: got=%0h exp=<scoreboard empty>", tag, tx_data_o);
    end else begin
      exp = sb.pop_front();
      chk(tag, {24'd0, tx_data_o}, {24'd0, exp});
      chk({tag, "_send"}, {31'd0, send_character_o}, 32'd1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    wr_en_i       = 1'b0;
    wr_data_i     = '0;
    flush_i       = 1'b0;
    tx_complete_i = 1'b0;
`ifdef KCUART_TX_BUF_OVF_EN
    ovf_clr_i     = 1'b0;
`endif
    step();
    step();
    // T1: reset state
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full",  {31'd0, full_o}, 32'd0);
    chk("rst_level", {27'd0, level_o}, 32'd0);
    chk("rst_send",  {31'd0, send_character_o}, 32'd0);
    chk("rst_data",  {24'd0, tx_data_o}, 32'd0);
`ifdef KCUART_TX_BUF_OVF_EN
    chk("rst_ovf",   {31'd0, ovf_o}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // T2: single byte, two-edge latency
    wr(8'hA5, 1'b1);
    chk("t2_empty_n", {31'd0, empty_o}, 32'd0);
    chk("t2_level1", {27'd0, level_o}, 32'd1);
    chk("t2_send0",  {31'd0, send_character_o}, 32'd0);
    step();
    chk_pop("t2_data");
    chk("t2_busy",   {31'd0, tx_busy_o}, 32'd1);
    chk("t2_level0", {27'd0, level_o}, 32'd0);
    step();
    chk("t2_hold",   {31'd0, send_character_o}, 32'd1);
    cmpl();
    chk("t2_done",   {31'd0, send_character_o}, 32'd0);
    chk("t2_keep",   {24'd0, tx_data_o}, 32'hA5);
    // tx_complete while idle is ignored
    cmpl();
    chk("idle_cmpl", {31'd0, send_character_o}, 32'd0);

    // T1b: reset mid-character
    wr(8'h5A, 1'b1);
    step();
    chk_pop("t1b_data");
    wr(8'h77, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t1b_send",  {31'd0, send_character_o}, 32'd0);
    chk("t1b_data0", {24'd0, tx_data_o}, 32'd0);
    chk("t1b_empty", {31'd0, empty_o}, 32'd1);
    chk("t1b_level", {27'd0, level_o}, 32'd0);
    step();
    rst_n = 1'b1;
    sb.delete();
    step();

    // T3: back-to-back characters
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    chk_pop("t3_b0");
    chk("t3_level", {27'd0, level_o}, 32'd2);
    cmpl();
    chk_pop("t3_b1");
    cmpl();
    chk_pop("t3_b2");
    cmpl();
    chk("t3_done", {31'd0, send_character_o}, 32'd0);
    chk("t3_keep", {24'd0, tx_data_o}, 32'h33);

    // T4: fill with transmitter stalled
    for (int i = 0; i < 17; i++) wr(8'h40 + 8'(i), 1'b1);
    chk("t4_full",  {31'd0, full_o}, 32'd1);
    chk("t4_level", {27'd0, level_o}, 32'd16);
    chk_pop("t4_b0");
    wr(8'hEE, 1'b0);
    chk("t4_drop_lvl",  {27'd0, level_o}, 32'd16);
    chk("t4_drop_full", {31'd0, full_o}, 32'd1);
`ifdef KCUART_TX_BUF_OVF_EN
    chk("t4_ovf", {31'd0, ovf_o}, 32'd1);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    chk("t4_ovf_clr", {31'd0, ovf_o}, 32'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      cmpl();
      chk_pop($sformatf("t4_drain%0d", i));
      if (i == 0) chk("t4_notfull", {31'd0, full_o}, 32'd0);
    end
    cmpl();
    chk("t4_done",  {31'd0, send_character_o}, 32'd0);
    chk("t4_empty", {31'd0, empty_o}, 32'd1);

    // T5: simultaneous write and pop at level 5
    for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i), 1'b1);
    chk_pop("t5_b0");
    chk("t5_level", {27'd0, level_o}, 32'd5);
    wr_en_i       = 1'b1;
    wr_data_i     = 8'h66;
    tx_complete_i = 1'b1;
    step();
    wr_en_i       = 1'b0;
    tx_complete_i = 1'b0;
    sb.push_back(8'h66);
    chk("t5_level_same", {27'd0, level_o}, 32'd5);
    chk_pop("t5_b1");
    for (int i = 0; i < 5; i++) begin
      cmpl();
      chk_pop($sformatf("t5_drain%0d", i));
    end
    cmpl();
    chk("t5_done", {31'd0, send_character_o}, 32'd0);

    // T6: flush during SEND with level 3
    for (int i = 0; i < 4; i++) wr(8'h70 + 8'(i), 1'b1);
    chk_pop("t6_b0");
    chk("t6_level3", {27'd0, level_o}, 32'd3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    sb.delete();
    chk("t6_level0", {27'd0, level_o}, 32'd0);
    chk("t6_empty",  {31'd0, empty_o}, 32'd1);
    step();
    step();
    chk("t6_send",   {31'd0, send_character_o}, 32'd1);
    chk("t6_data",   {24'd0, tx_data_o}, 32'h70);
    cmpl();
    chk("t6_idle",   {31'd0, send_character_o}, 32'd0);
    chk("t6_keep",   {24'd0, tx_data_o}, 32'h70);

    // Flush discards a same-cycle write
    flush_i   = 1'b1;
    wr_en_i   = 1'b1;
    wr_data_i = 8'h99;
    step();
    flush_i   = 1'b0;
    wr_en_i   = 1'b0;
    chk("fl_wr_level", {27'd0, level_o}, 32'd0);
    step();
    chk("fl_wr_send",  {31'd0, send_character_o}, 32'd0);

    // FSM usable after flush return to IDLE
    wr(8'hC3, 1'b1);
    step();
    chk_pop("post_flush");
    cmpl();
    chk("post_done", {31'd0, send_character_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
